// File: rtl/icache_param_plru.sv
// Parametrised set-associative read-only instruction cache with tree-PLRU replacement
// and whole-cache invalidate. Define ICACHE_PERF_CNT_EN to add hit/miss counters.
module icache_param_plru #(
  parameter int unsigned NUM_WAY    = 4,
  parameter int unsigned NUM_SET    = 16,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        from_cpu_inst_req_valid,
  input  logic [31:0] from_cpu_inst_req_addr,
  output logic        to_cpu_inst_req_ready,
  output logic        to_cpu_cache_rsp_valid,
  output logic [31:0] to_cpu_cache_rsp_data,
  input  logic        from_cpu_cache_rsp_ready,
  input  logic        from_cpu_inv_valid,
  output logic        to_cpu_inv_ready,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam int unsigned SET_W = $clog2(NUM_SET);
  localparam int unsigned TAG_W = 32 - SET_W - OFF_W;
  localparam int unsigned WAY_W = $clog2(NUM_WAY);

  typedef enum logic [7:0] {
    S_WAIT     = 8'h01,
    S_TAG_RD   = 8'h02,
    S_EVICT    = 8'h04,
    S_MEM_RD   = 8'h08,
    S_RECV     = 8'h10,
    S_CACHE_RD = 8'h20,
    S_REFILL   = 8'h40,
    S_RESP     = 8'h80
  } state_t;

  state_t state;

  logic [31:0]        req_addr;
  logic [TAG_W-1:0]   req_tag;
  logic [SET_W-1:0]   req_set;
  logic [IDX_W-1:0]   req_word;
  logic               unused_addr_bits;

  logic [NUM_WAY-1:0] valid    [NUM_SET];
  logic [NUM_WAY-1:1] plru     [NUM_SET];
  logic [TAG_W-1:0]   tag_arr  [NUM_WAY][NUM_SET];
  logic [31:0]        data_arr [NUM_WAY][NUM_SET][LINE_WORDS];
  logic [31:0]        line_buf [LINE_WORDS];

  logic [IDX_W:0]     beat_cnt;
  logic               beat_store;
  logic [WAY_W-1:0]   hit_way, victim;
  logic [WAY_W-1:0]   hit_way_c, victim_c;
  logic               hit_c, invalid_found;
  logic [WAY_W:0]     walk_node;
  logic [31:0]        rsp_data_q;

  assign req_tag          = req_addr[31:OFF_W+SET_W];
  assign req_set          = req_addr[OFF_W+SET_W-1:OFF_W];
  assign req_word         = req_addr[OFF_W-1:2];
  assign unused_addr_bits = ^req_addr[1:0];

  assign to_cpu_inst_req_ready  = (state == S_WAIT);
  assign to_cpu_inv_ready       = (state == S_WAIT);
  assign to_cpu_cache_rsp_valid = (state == S_RESP);
  assign to_cpu_cache_rsp_data  = rsp_data_q;
  assign to_mem_rd_req_valid    = (state == S_MEM_RD);
  assign to_mem_rd_req_addr     = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign to_mem_rd_rsp_ready    = (state == S_RECV);

  assign beat_store = (state == S_RECV) && from_mem_rd_rsp_valid &&
                      (beat_cnt < (IDX_W+1)'(LINE_WORDS));

  // Each node on the path points away from the touched way (1 = right).
  function automatic logic [NUM_WAY-1:1] plru_touch(input logic [NUM_WAY-1:1] cur,
                                                    input logic [WAY_W-1:0] way);
    logic [WAY_W:0] node;
    plru_touch = cur;
    node       = {1'b1, way};
    for (int unsigned l = 0; l < WAY_W; l++) begin
      plru_touch[node[WAY_W:1]] = ~node[0];
      node = node >> 1;
    end
  endfunction

  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int unsigned w = 0; w < NUM_WAY; w++) begin
      if (!hit_c && valid[req_set][WAY_W'(w)] && tag_arr[WAY_W'(w)][req_set] == req_tag) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  always_comb begin
    invalid_found = 1'b0;
    victim_c      = '0;
    walk_node     = (WAY_W+1)'(1);
    for (int unsigned w = 0; w < NUM_WAY; w++) begin
      if (!invalid_found && !valid[req_set][WAY_W'(w)]) begin
        invalid_found = 1'b1;
        victim_c      = WAY_W'(w);
      end
    end
    for (int unsigned l = 0; l < WAY_W; l++)
      walk_node = {walk_node[WAY_W-1:0], plru[req_set][walk_node[WAY_W-1:0]]};
    if (!invalid_found)
      victim_c = walk_node[WAY_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT;
      req_addr   <= '0;
      beat_cnt   <= '0;
      hit_way    <= '0;
      victim     <= '0;
      rsp_data_q <= '0;
      for (int unsigned s = 0; s < NUM_SET; s++) begin
        valid[SET_W'(s)] <= '0;
        plru[SET_W'(s)]  <= '0;
      end
`ifdef ICACHE_PERF_CNT_EN
      hit_cnt  <= '0;
      miss_cnt <= '0;
`endif
    end else begin
      case (state)
        S_WAIT: begin
          if (from_cpu_inv_valid) begin
            for (int unsigned s = 0; s < NUM_SET; s++) begin
              valid[SET_W'(s)] <= '0;
              plru[SET_W'(s)]  <= '0;
            end
          end else if (from_cpu_inst_req_valid) begin
            req_addr <= from_cpu_inst_req_addr;
            state    <= S_TAG_RD;
          end
        end
        S_TAG_RD: begin
          hit_way <= hit_way_c;
          state   <= hit_c ? S_CACHE_RD : S_EVICT;
`ifdef ICACHE_PERF_CNT_EN
          if (hit_c) hit_cnt  <= hit_cnt + 32'd1;
          else       miss_cnt <= miss_cnt + 32'd1;
`endif
        end
        S_EVICT: begin
          victim <= victim_c;
          state  <= S_MEM_RD;
        end
        S_MEM_RD: begin
          if (from_mem_rd_req_ready) begin
            beat_cnt <= '0;
            state    <= S_RECV;
          end
        end
        S_RECV: begin
          if (beat_store)
            beat_cnt <= beat_cnt + 1'b1;
          if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last)
            state <= S_REFILL;
        end
        S_CACHE_RD: begin
          rsp_data_q    <= data_arr[hit_way][req_set][req_word];
          plru[req_set] <= plru_touch(plru[req_set], hit_way);
          state         <= S_RESP;
        end
        S_REFILL: begin
          rsp_data_q             <= line_buf[req_word];
          valid[req_set][victim] <= 1'b1;
          plru[req_set]          <= plru_touch(plru[req_set], victim);
          state                  <= S_RESP;
        end
        S_RESP: begin
          if (from_cpu_cache_rsp_ready)
            state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (beat_store)
      line_buf[beat_cnt[IDX_W-1:0]] <= from_mem_rd_rsp_data;
    if (state == S_REFILL) begin
      tag_arr[victim][req_set] <= req_tag;
      for (int unsigned i = 0; i < LINE_WORDS; i++)
        data_arr[victim][req_set][IDX_W'(i)] <= line_buf[IDX_W'(i)];
    end
  end

endmodule

// File: tb/tb_icache_param_plru.sv
// Directed self-checking bench for icache_param_plru (default 4-way, 16-set, 8-word lines).
module tb_icache_param_plru;

  localparam int LINE_WORDS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        from_cpu_inst_req_valid = 1'b0;
  logic [31:0] from_cpu_inst_req_addr = '0;
  logic        to_cpu_inst_req_ready;
  logic        to_cpu_cache_rsp_valid;
  logic [31:0] to_cpu_cache_rsp_data;
  logic        from_cpu_cache_rsp_ready = 1'b1;
  logic        from_cpu_inv_valid = 1'b0;
  logic        to_cpu_inv_ready;
  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic        from_mem_rd_req_ready = 1'b0;
  logic        from_mem_rd_rsp_valid = 1'b0;
  logic [31:0] from_mem_rd_rsp_data = '0;
  logic        from_mem_rd_rsp_last = 1'b0;
  logic        to_mem_rd_rsp_ready;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic        gm, tmo;
  logic [31:0] ma, dt;
  int          lt;

  icache_param_plru #(.NUM_WAY(4), .NUM_SET(16), .LINE_WORDS(LINE_WORDS)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
    .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
    .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
    .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
    .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
    .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
    .from_cpu_inv_valid       (from_cpu_inv_valid),
    .to_cpu_inv_ready         (to_cpu_inv_ready),
    .to_mem_rd_req_valid      (to_mem_rd_req_valid),
    .to_mem_rd_req_addr       (to_mem_rd_req_addr),
    .from_mem_rd_req_ready    (from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt                  (hit_cnt),
    .miss_cnt                 (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Issues one fetch, services any line read with beats base+i, returns observations.
  // lat counts falling edges after the accepting edge until rsp_valid is seen.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] base,
                       output logic got_mem, output logic [31:0] mem_addr,
                       output logic [31:0] data, output int lat, output logic timeout);
    int n;
    got_mem = 1'b0; mem_addr = '0; data = '0; lat = 0; timeout = 1'b1;
    @(negedge clk);
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = addr;
    n = 0;
    while (!to_cpu_inst_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 from_cpu_inst_req_valid = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (to_cpu_cache_rsp_valid) begin
        data = to_cpu_cache_rsp_data;
        lat = k;
        timeout = 1'b0;
        break;
      end
      if (to_mem_rd_req_valid && !got_mem) begin
        got_mem  = 1'b1;
        mem_addr = to_mem_rd_req_addr;
        from_mem_rd_req_ready = 1'b1;
        @(posedge clk);
        #1 from_mem_rd_req_ready = 1'b0;
        for (int i = 0; i < LINE_WORDS; i++) begin
          from_mem_rd_rsp_valid = 1'b1;
          from_mem_rd_rsp_data  = base + 32'(i);
          from_mem_rd_rsp_last  = (i == LINE_WORDS - 1);
          @(posedge clk);
          #1;
        end
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_last  = 1'b0;
      end
    end
    if (from_cpu_cache_rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (to_cpu_inst_req_ready !== 1'b1) begin failures++; $display("FAIL rst_inst_ready act=%b exp=1", to_cpu_inst_req_ready); end
    checks++; if (to_cpu_inv_ready !== 1'b1) begin failures++; $display("FAIL rst_inv_ready act=%b exp=1", to_cpu_inv_ready); end
    checks++; if (to_cpu_cache_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid act=%b exp=0", to_cpu_cache_rsp_valid); end
    checks++; if (to_mem_rd_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_req_valid act=%b exp=0", to_mem_rd_req_valid); end
    checks++; if (to_mem_rd_rsp_ready !== 1'b0) begin failures++; $display("FAIL rst_mem_rsp_ready act=%b exp=0", to_mem_rd_rsp_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (to_cpu_inst_req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_inst_ready act=%b exp=1", to_cpu_inst_req_ready); end
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_0104, 32'hA0, gm, ma, dt, lt, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL t1_timeout act=%b exp=0", tmo); end
    checks++; if (gm !== 1'b1) begin failures++; $display("FAIL t1_mem_req act=%b exp=1", gm); end
    checks++; if (ma !== 32'h100) begin failures++; $display("FAIL t1_mem_addr act=%h exp=00000100", ma); end
    checks++; if (dt !== 32'hA1) begin failures++; $display("FAIL t1_data act=%h exp=000000a1", dt); end
  endtask

  task automatic test_hit();
    fetch(32'h0000_0108, 32'hEE, gm, ma, dt, lt, tmo);
    checks++; if (gm !== 1'b0) begin failures++; $display("FAIL t2_mem_req act=%b exp=0", gm); end
    checks++; if (lt !== 3) begin failures++; $display("FAIL t2_latency act=%0d exp=3", lt); end
    checks++; if (dt !== 32'hA2) begin failures++; $display("FAIL t2_data act=%h exp=000000a2", dt); end
  endtask

  task automatic test_plru();
    for (int k = 0; k < 5; k++) begin
      fetch(32'(k) * 32'h200, 32'h1000 * 32'(k + 1), gm, ma, dt, lt, tmo);
      checks++; if (gm !== 1'b1) begin failures++; $display("FAIL t3_fill%0d_mem_req act=%b exp=1", k, gm); end
      checks++; if (dt !== 32'h1000 * 32'(k + 1)) begin failures++; $display("FAIL t3_fill%0d_data act=%h exp=%h", k, dt, 32'h1000 * 32'(k + 1)); end
    end
    // tag4 took way0; tree now 1,1,0 so the next victim is way2.
    fetch(32'h800, 32'hDEAD, gm, ma, dt, lt, tmo);
    checks++; if (gm !== 1'b0 || dt !== 32'h5000) begin failures++; $display("FAIL t3_tag4_hit act=mem%b/%h exp=mem0/00005000", gm, dt); end
    fetch(32'h000, 32'h6000, gm, ma, dt, lt, tmo);
    checks++; if (gm !== 1'b1 || dt !== 32'h6000) begin failures++; $display("FAIL t3_tag0_refetch act=mem%b/%h exp=mem1/00006000", gm, dt); end
    fetch(32'h400, 32'h7000, gm, ma, dt, lt, tmo);
    checks++; if (gm !== 1'b1 || dt !== 32'h7000) begin failures++; $display("FAIL t3_tag2_evicted act=mem%b/%h exp=mem1/00007000", gm, dt); end
    fetch(32'h600, 32'hDEAD, gm, ma, dt, lt, tmo);
    checks++; if (gm !== 1'b0 || dt !== 32'h4000) begin failures++; $display("FAIL t3_tag3_hit act=mem%b/%h exp=mem0/00004000", gm, dt); end
    fetch(32'h200, 32'h8000, gm, ma, dt, lt, tmo);
    checks++; if (gm !== 1'b1 || dt !== 32'h8000) begin failures++; $display("FAIL t3_tag1_evicted act=mem%b/%h exp=mem1/00008000", gm, dt); end
  endtask

  task automatic test_invalidate();
    @(negedge clk);
    from_cpu_inv_valid      = 1'b1;
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = 32'h104;
    checks++; if (to_cpu_inv_ready !== 1'b1) begin failures++; $display("FAIL t4_inv_ready act=%b exp=1", to_cpu_inv_ready); end
    @(posedge clk);
    #1;
    from_cpu_inv_valid      = 1'b0;
    from_cpu_inst_req_valid = 1'b0;
    checks++; if (to_cpu_inst_req_ready !== 1'b1) begin failures++; $display("FAIL t4_req_not_taken act=%b exp=1", to_cpu_inst_req_ready); end
    fetch(32'h104, 32'hA0, gm, ma, dt, lt, tmo);
    checks++; if (gm !== 1'b1 || ma !== 32'h100) begin failures++; $display("FAIL t4_refetch_mem act=mem%b/%h exp=mem1/00000100", gm, ma); end
    checks++; if (dt !== 32'hA1) begin failures++; $display("FAIL t4_data act=%h exp=000000a1", dt); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic saw_mem;
    from_cpu_cache_rsp_ready = 1'b0;
    fetch(32'h108, 32'hDEAD, gm, ma, dt, lt, tmo);
    checks++; if (tmo !== 1'b0 || dt !== 32'hA2) begin failures++; $display("FAIL t5_first_data act=to%b/%h exp=to0/000000a2", tmo, dt); end
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = 32'h10C;
    from_cpu_inv_valid      = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (to_cpu_cache_rsp_valid !== 1'b1 || to_cpu_cache_rsp_data !== 32'hA2) begin failures++; $display("FAIL t5_stall%0d_hold act=%b/%h exp=1/000000a2", c, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data); end
      checks++; if (to_cpu_inst_req_ready !== 1'b0 || to_cpu_inv_ready !== 1'b0) begin failures++; $display("FAIL t5_stall%0d_ready act=%b/%b exp=0/0", c, to_cpu_inst_req_ready, to_cpu_inv_ready); end
    end
    from_cpu_inv_valid       = 1'b0;
    from_cpu_cache_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (to_cpu_cache_rsp_valid !== 1'b0 || to_cpu_inst_req_ready !== 1'b1) begin failures++; $display("FAIL t5_release act=%b/%b exp=0/1", to_cpu_cache_rsp_valid, to_cpu_inst_req_ready); end
    @(posedge clk);
    #1;
    from_cpu_inst_req_valid = 1'b0;
    checks++; if (to_cpu_inst_req_ready !== 1'b0) begin failures++; $display("FAIL t5_next_accept act=%b exp=0", to_cpu_inst_req_ready); end
    saw_mem = 1'b0;
    n = 0;
    while (!to_cpu_cache_rsp_valid && n < 20) begin
      @(negedge clk);
      if (to_mem_rd_req_valid) saw_mem = 1'b1;
      n++;
    end
    checks++; if (to_cpu_cache_rsp_valid !== 1'b1 || saw_mem !== 1'b0 || to_cpu_cache_rsp_data !== 32'hA3) begin failures++; $display("FAIL t5_second_hit act=v%b/mem%b/%h exp=v1/mem0/000000a3", to_cpu_cache_rsp_valid, saw_mem, to_cpu_cache_rsp_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_burst();
    int n;
    @(negedge clk);
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = 32'h3000;
    @(posedge clk);
    #1 from_cpu_inst_req_valid = 1'b0;
    n = 0;
    while (!to_mem_rd_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (to_mem_rd_req_valid !== 1'b1) begin failures++; $display("FAIL t6_mem_req act=%b exp=1", to_mem_rd_req_valid); end
    from_mem_rd_req_ready = 1'b1;
    @(posedge clk);
    #1 from_mem_rd_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      from_mem_rd_rsp_valid = 1'b1;
      from_mem_rd_rsp_data  = 32'hC0 + 32'(i);
      @(posedge clk);
      #1;
    end
    from_mem_rd_rsp_data = 32'hC4;
    #1 rst = 1'b1;
    #1;
    checks++; if (to_cpu_inst_req_ready !== 1'b1 || to_mem_rd_rsp_ready !== 1'b0) begin failures++; $display("FAIL t6_abort act=%b/%b exp=1/0", to_cpu_inst_req_ready, to_mem_rd_rsp_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (to_mem_rd_rsp_ready !== 1'b0 || to_cpu_inst_req_ready !== 1'b1) begin failures++; $display("FAIL t6_beats_refused act=%b/%b exp=0/1", to_mem_rd_rsp_ready, to_cpu_inst_req_ready); end
    from_mem_rd_rsp_valid = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin failures++; $display("FAIL t6_cnt_reset act=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
`endif
    fetch(32'h3000, 32'hD0, gm, ma, dt, lt, tmo);
    checks++; if (gm !== 1'b1 || ma !== 32'h3000 || dt !== 32'hD0) begin failures++; $display("FAIL t6_refetch act=mem%b/%h/%h exp=mem1/00003000/000000d0", gm, ma, dt); end
`ifdef ICACHE_PERF_CNT_EN
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1) begin failures++; $display("FAIL t6_cnt_after act=%0d/%0d exp=0/1", hit_cnt, miss_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_plru();
    test_invalidate();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
